// File: rtl/ram_scan_reader_pkg.sv
// Shared widths, types and helpers for the RAM scan reader slice.
package ram_scan_pkg;

  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 4;

  typedef logic [RAM_ADDR_W-1:0] addr_t;
  typedef logic [RAM_DATA_W-1:0] data_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } rd_tag_t;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_scan_reader_if.sv
// RAM read port, display output and RAM write snoop for ram_scan_reader.
interface ram_scan_reader_if
  import ram_scan_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
);
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rd_addr, disp_addr, disp_data, disp_valid,
    input  rd_data, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rd_addr, disp_addr, disp_data, disp_valid,
    output rd_data, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/ram_scan_reader_tick_prescaler.sv
// Enable-gated modulo-TICK_COUNT prescaler; tick is high on the last count.
module tick_prescaler
  import ram_scan_pkg::*;
#(
  parameter int unsigned TICK_COUNT = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int unsigned CNT_W = cnt_width(TICK_COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_COUNT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count enabled cycles, wrapping to zero on the tick cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ram_scan_reader.sv
// Read-side sequencer for the scanned RAM: steps the read address at the
// prescaler rate and presents each returned word with its address.
// Optional feature macro: RAM_WRITE_BYPASS_EN (snoops RAM writes to the
// displayed address so the display never shows stale data).
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int unsigned ADDR_W     = RAM_ADDR_W,
  parameter int unsigned DATA_W     = RAM_DATA_W,
  parameter int unsigned TICK_COUNT = 50_000_000,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  ram_scan_reader_if.master bus
);
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } tag_t;

  logic              tick;
  logic              prime;
  logic              issue_v;
  logic [ADDR_W-1:0] rd_addr_q;
  tag_t              pipe [RD_LAT];
  tag_t              exit_tag;

  logic [ADDR_W-1:0] disp_addr_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              disp_valid_q;
  logic [ADDR_W-1:0] disp_addr_d;
  logic [DATA_W-1:0] disp_data_d;
  logic              disp_valid_d;

  tick_prescaler #(.TICK_COUNT(TICK_COUNT)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  // Issue stage: the prime read of word 0 takes precedence over a tick that
  // lands on the same cycle, so word 0 is never skipped after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prime     <= 1'b1;
      issue_v   <= 1'b0;
      rd_addr_q <= '0;
    end else if (prime) begin
      prime     <= 1'b0;
      issue_v   <= 1'b1;
    end else if (tick) begin
      issue_v   <= 1'b1;
      rd_addr_q <= rd_addr_q + 1'b1;
    end else begin
      issue_v   <= 1'b0;
    end
  end

  // Tag pipeline: issue_v marks the cycle the address is on the RAM port;
  // RD_LAT further stages line the tag up with the returned word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {issue_v, rd_addr_q};
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign exit_tag = pipe[RD_LAT-1];

  // Display update: capture an exiting tag, optionally patched by a
  // concurrent write to the same word.
  always_comb begin
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    if (exit_tag.valid) begin
      disp_addr_d  = exit_tag.addr;
      disp_data_d  = bus.rd_data;
      disp_valid_d = 1'b1;
`ifdef RAM_WRITE_BYPASS_EN
      if (bus.wr_en && (bus.wr_addr == exit_tag.addr)) disp_data_d = bus.wr_data;
`endif
    end
`ifdef RAM_WRITE_BYPASS_EN
    else if (bus.wr_en && (bus.wr_addr == disp_addr_q)) begin
      disp_data_d  = bus.wr_data;
      disp_valid_d = 1'b1;
    end
`endif
  end

  // Display registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

`ifndef RAM_WRITE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{bus.wr_en, bus.wr_addr, bus.wr_data};
`endif

  assign bus.rd_addr    = rd_addr_q;
  assign bus.disp_addr  = disp_addr_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
endmodule
